issue_unit: RTL and testbench
=============================

Name: issue_unit

Overview:
Tomasulo issue stage, directly downstream of the 8-entry instruction queue. Pops one 16-bit instruction at a time, decodes it and allocates a free reservation station of the matching class. Renames the destination through an internal 8-entry register status table (RST) and sends source tags/indices to the station. Snoops the CDB to retire RST tags.

Parameters:
INSTR_W, 16, instruction width (only default supported)
TAG_W, 3, station tag width; tag 0 = "value ready / no producer"

Ports:
CLK  in  1  clock, rising edge
CLR  in  1  asynchronous reset, active-high
q_empty  in  1  queue empty flag (frente==tras; also high when queue full)
q_full  in  1  queue full flag
q_push  in  1  queue add request this cycle (add has priority over retire in the queue)
q_instr  in  16  queue registered output
q_pop  out  1  retire request to queue
rs_busy  in  7  busy bit per station, bit i-1 = tag i; tags 1-3 ADD/SUB, 4-5 MUL/DIV, 6-7 LD
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  3  tag being broadcast
issue_valid  out  1  one-cycle pulse: issue_* fields valid
issue_tag  out  3  allocated station tag
issue_op  out  3  opcode
issue_rj, issue_rk  out  3 each  source register indices (for value read)
issue_qj, issue_qk  out  3 each  source producer tags (0 = read register file)
issue_imm  out  7  LD offset (0 for ALU ops)
stall  out  1  high while decoded instruction waits for a free station
rst_tags  out  24  RST tag of reg i at bits [3i+2:3i] (debug/regfile)

Behaviour:
- Encoding: op[15:13], rd[12:10], rs[9:7], rt[6:4]; LD: imm[6:0] replaces rt. Ops 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 LD; 101-111 illegal.
- Queue non-empty: nonempty = ~q_empty | q_full.
- FSM, states IDLE, REQ, DECODE, ISSUE. q_pop = (state==REQ), Moore.
- IDLE: to REQ when nonempty.
- REQ: to DECODE when nonempty & ~q_push at the edge (pop accepted). Otherwise stay in REQ if nonempty, else go to IDLE.
- DECODE: latch q_instr into IR. Illegal op: discard, go to REQ if nonempty, else IDLE. Legal op: go to ISSUE.
- ISSUE: choose the lowest free tag of IR's class (~rs_busy).
  - None free: stall=1, stay in ISSUE, nothing changes.
  - Free tag found: at the edge register issue_valid=1 and all issue_* fields, write RST[rd]=tag, then go to REQ/IDLE as above. Minimum 3 cycles per instruction.
- Source tags: qj = RST[rs], qk = RST[rt] (qk=0 for LD), both read before the rd update, so rd==rs yields the old tag. If cdb_valid and cdb_tag equals the read tag in the issue cycle, the issued tag is 0 (bypass).
- CDB: every cycle, each RST entry whose tag == cdb_tag (nonzero) is cleared to 0. An issue write to RST[rd] in the same edge wins over the clear.
- issue_valid drops to 0 the cycle after the pulse; other issue_* fields hold their values.
- CLR, any time including mid-ISSUE: state=IDLE, IR=0, RST all 0, q_pop=0, issue_valid=0, all issue_* =0, stall=0. An instruction popped but not yet issued is lost.

Test Plan:
- Reset, queue holds ADD r1,r2,r3 (0x0530), rs_busy=0 -> q_pop 1 cycle, issue_valid 2 cycles later, tag=1, qj=qk=0, rst_tags[5:3]=1.
- Then MUL r4,r1,r1 (0x5090), no CDB -> tag=4, qj=qk=1, RST[4]=4. Repeat with cdb_valid=1, cdb_tag=1 in the issue cycle -> qj=qk=0, RST[1]=0.
- rs_busy=7'b0000111, ADD pending -> stall=1, no issue for 5 cycles; clear bit 1 -> issue_tag=2, stall=0.
- q_push=1 during REQ (queue full) -> stays in REQ, no DECODE. Drop q_push -> pop accepted. With q_empty=1 and q_full=1, the block still pops.
- Opcode 110 followed by LD r5,r2,#9 -> illegal instruction dropped with no pulse; LD issues tag=6, imm=9, qk=0.
- CLR asserted in ISSUE with stall=1 -> all outputs 0 asynchronously, RST cleared, FSM in IDLE.

Source files
------------

// File: rtl/issue_unit.sv
// Tomasulo issue stage: pops the instruction queue, decodes, allocates a reservation
// station by class, renames the destination in an 8-entry register status table.
module issue_unit #(
    parameter int INSTR_W = 16,
    parameter int TAG_W   = 3
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 q_empty,
    input  logic                 q_full,
    input  logic                 q_push,
    input  logic [INSTR_W-1:0]   q_instr,
    output logic                 q_pop,
    input  logic [6:0]           rs_busy,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    output logic                 issue_valid,
    output logic [TAG_W-1:0]     issue_tag,
    output logic [2:0]           issue_op,
    output logic [2:0]           issue_rj,
    output logic [2:0]           issue_rk,
    output logic [TAG_W-1:0]     issue_qj,
    output logic [TAG_W-1:0]     issue_qk,
    output logic [6:0]           issue_imm,
    output logic                 stall,
    output logic [8*TAG_W-1:0]   rst_tags
);

    localparam int unsigned NST  = 7;
    localparam int unsigned NREG = 8;

    typedef enum logic [1:0] {IDLE, REQ, DECODE, ISSUE} state_t;
    typedef enum logic [2:0] {OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2,
                              OP_DIV = 3'd3, OP_LD = 3'd4} op_e;

    state_t               state, state_nx;
    logic [INSTR_W-1:0]   ir;
    logic [TAG_W-1:0]     rst_q [NREG];

    logic                 nonempty;
    logic                 q_illegal;
    logic [2:0]           ir_op, ir_rd, ir_rs, ir_rt;
    logic                 is_ld;
    logic [NST-1:0]       cls_mask, avail;
    logic                 free_found;
    logic [TAG_W-1:0]     free_tag;
    logic                 do_issue;
    logic [TAG_W-1:0]     tj, tk, qj_nx, qk_nx;

    assign nonempty  = ~q_empty | q_full;
    assign q_illegal = q_instr[15:13] > OP_LD;

    assign ir_op = ir[15:13];
    assign ir_rd = ir[12:10];
    assign ir_rs = ir[9:7];
    assign ir_rt = ir[6:4];
    assign is_ld = (ir_op == OP_LD);

    always_comb begin
        case (ir_op)
            OP_ADD, OP_SUB: cls_mask = 7'b0000111;
            OP_MUL, OP_DIV: cls_mask = 7'b0011000;
            default:        cls_mask = 7'b1100000;
        endcase
    end

    // Descending scan so the lowest free tag is the one left assigned.
    always_comb begin
        avail      = cls_mask & ~rs_busy;
        free_found = |avail;
        free_tag   = '0;
        for (int unsigned i = NST; i >= 1; i--) begin
            if (avail[i-1]) free_tag = TAG_W'(i);
        end
    end

    assign do_issue = (state == ISSUE) && free_found;

    // A tag broadcast on the CDB this cycle is already resolved: forward 0.
    always_comb begin
        tj    = rst_q[ir_rs];
        tk    = rst_q[ir_rt];
        qj_nx = (cdb_valid && cdb_tag == tj) ? '0 : tj;
        qk_nx = (is_ld || (cdb_valid && cdb_tag == tk)) ? '0 : tk;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        case (state)
            IDLE:   if (nonempty) state_nx = REQ;
            REQ: begin
                if (nonempty && !q_push) state_nx = DECODE;
                else if (nonempty)       state_nx = REQ;
                else                     state_nx = IDLE;
            end
            DECODE: begin
                if (q_illegal) state_nx = nonempty ? REQ : IDLE;
                else           state_nx = ISSUE;
            end
            ISSUE: begin
                if (!free_found) stall    = 1'b1;
                else             state_nx = nonempty ? REQ : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign q_pop = (state == REQ);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR)                  ir <= '0;
        else if (state == DECODE) ir <= q_instr;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            issue_valid <= 1'b0;
            issue_tag   <= '0;
            issue_op    <= '0;
            issue_rj    <= '0;
            issue_rk    <= '0;
            issue_qj    <= '0;
            issue_qk    <= '0;
            issue_imm   <= '0;
        end else begin
            issue_valid <= 1'b0;
            if (do_issue) begin
                issue_valid <= 1'b1;
                issue_tag   <= free_tag;
                issue_op    <= ir_op;
                issue_rj    <= ir_rs;
                issue_rk    <= is_ld ? 3'd0 : ir_rt;
                issue_qj    <= qj_nx;
                issue_qk    <= qk_nx;
                issue_imm   <= is_ld ? ir[6:0] : 7'd0;
            end
        end
    end

    // Rename write takes precedence over a same-edge CDB clear of that entry.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int unsigned i = 0; i < NREG; i++) rst_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (do_issue && ir_rd == 3'(i))
                    rst_q[i] <= free_tag;
                else if (cdb_valid && cdb_tag != '0 && rst_q[i] == cdb_tag)
                    rst_q[i] <= '0;
            end
        end
    end

    always_comb begin
        rst_tags = '0;
        for (int unsigned i = 0; i < NREG; i++) rst_tags[i*TAG_W +: TAG_W] = rst_q[i];
    end

endmodule

// File: tb/tb_issue_unit.sv
// Randomized scoreboard bench for issue_unit with an external queue model and
// a transaction-level rename model.
module tb_issue_unit;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        q_empty, q_full, q_push;
    logic [15:0] q_instr;
    logic        q_pop;
    logic [6:0]  rs_busy;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic        issue_valid;
    logic [2:0]  issue_tag, issue_op, issue_rj, issue_rk, issue_qj, issue_qk;
    logic [6:0]  issue_imm;
    logic        stall;
    logic [23:0] rst_tags;

    always #5 CLK = ~CLK;

    issue_unit #(.INSTR_W(16), .TAG_W(3)) dut (
        .CLK(CLK), .CLR(CLR), .q_empty(q_empty), .q_full(q_full), .q_push(q_push),
        .q_instr(q_instr), .q_pop(q_pop), .rs_busy(rs_busy), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .issue_valid(issue_valid), .issue_tag(issue_tag),
        .issue_op(issue_op), .issue_rj(issue_rj), .issue_rk(issue_rk),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_imm(issue_imm),
        .stall(stall), .rst_tags(rst_tags)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] fifo[$];   // external instruction queue contents
    logic [15:0] expq[$];   // popped legal instructions awaiting their issue pulse
    logic [2:0]  mrst[8];   // register -> producing tag

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lowest_free(logic [2:0] op, logic [6:0] busy);
        int lo, hi;
        if (op <= 3'd1)      begin lo = 1; hi = 3; end
        else if (op <= 3'd3) begin lo = 4; hi = 5; end
        else                 begin lo = 6; hi = 7; end
        for (int t = lo; t <= hi; t++) if (!busy[t-1]) return t;
        return 0;
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [2:0] op;
        op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        return {op, 13'($urandom)};
    endfunction

    function automatic int src_tag(logic [2:0] t, logic cv, logic [2:0] ct);
        return (cv && ct == t) ? 0 : int'(t);
    endfunction

    // Called at posedge+1: settles the queue for the edge just taken, draws new inputs.
    task automatic step(int push_pct, int busy_pct, int cdb_pct);
        logic push_acc, pop_acc, nonempty;
        nonempty = !q_empty || q_full;
        push_acc = q_push && fifo.size() < 8;
        pop_acc  = q_pop && nonempty && !q_push;
        @(posedge CLK); #1;
        if (push_acc) fifo.push_back(rand_instr());
        else if (pop_acc) begin
            q_instr = fifo.pop_front();
            if (q_instr[15:13] <= 3'd4) expq.push_back(q_instr);
        end
        q_full    = (fifo.size() == 8);
        q_empty   = (fifo.size() == 0) || q_full;
        q_push    = ($urandom_range(0, 99) < push_pct) && !CLR;
        for (int b = 0; b < 7; b++) rs_busy[b] = ($urandom_range(0, 99) < busy_pct);
        cdb_valid = ($urandom_range(0, 99) < cdb_pct);
        cdb_tag   = 3'($urandom_range(0, 7));
    endtask

    // Monitor: at each falling edge, account for the preceding rising edge.
    initial begin
        logic        pv_iv, pv_cv, wr;
        logic [2:0]  pv_ct, wr_rd;
        logic [6:0]  pv_busy;
        logic [15:0] ins;
        logic [2:0]  op, rd, rs, rt;
        logic [23:0] exp24;
        int          etag;
        pv_iv = 0; pv_cv = 0; pv_ct = 0; pv_busy = 0;
        for (int i = 0; i < 8; i++) mrst[i] = 0;
        forever begin
            @(negedge CLK);
            wr = 0; wr_rd = 0; etag = 0;
            if (CLR) begin
                for (int i = 0; i < 8; i++) mrst[i] = 0;
                expq.delete();
                chk("reset_ctl", int'({q_pop, issue_valid, stall}), 0);
                chk("reset_fields", int'({issue_tag, issue_op, issue_rj, issue_rk,
                                          issue_qj, issue_qk, issue_imm}), 0);
                chk("reset_rst", int'(rst_tags), 0);
                pv_iv = 0;
            end else begin
                if (issue_valid) begin
                    chk("pulse_width", int'(pv_iv), 0);
                    if (expq.size() == 0) chk("unexpected_issue", 1, 0);
                    else begin
                        ins = expq.pop_front();
                        op = ins[15:13]; rd = ins[12:10]; rs = ins[9:7]; rt = ins[6:4];
                        etag = lowest_free(op, pv_busy);
                        chk("issue_tag", int'(issue_tag), etag);
                        chk("issue_op",  int'(issue_op), int'(op));
                        chk("issue_rj",  int'(issue_rj), int'(rs));
                        chk("issue_rk",  int'(issue_rk), (op == 3'd4) ? 0 : int'(rt));
                        chk("issue_qj",  int'(issue_qj), src_tag(mrst[rs], pv_cv, pv_ct));
                        chk("issue_qk",  int'(issue_qk),
                            (op == 3'd4) ? 0 : src_tag(mrst[rt], pv_cv, pv_ct));
                        chk("issue_imm", int'(issue_imm), (op == 3'd4) ? int'(ins[6:0]) : 0);
                        wr = 1; wr_rd = rd;
                    end
                end
                if (pv_cv && pv_ct != 0)
                    for (int i = 0; i < 8; i++) if (mrst[i] == pv_ct) mrst[i] = 0;
                if (wr) mrst[wr_rd] = 3'(etag);
                for (int i = 0; i < 8; i++) exp24[3*i +: 3] = mrst[i];
                chk("rst_tags", int'(rst_tags), int'(exp24));
                if (stall) begin
                    chk("stall_pending", int'(expq.size() > 0), 1);
                    if (expq.size() > 0) begin
                        ins = expq[0];
                        chk("stall_no_free", lowest_free(ins[15:13], rs_busy), 0);
                    end
                end
                pv_iv = issue_valid;
            end
            pv_cv = cdb_valid; pv_ct = cdb_tag; pv_busy = rs_busy;
        end
    end

    initial begin
        int n;
        logic [15:0] a;
        CLR = 1; q_push = 0; q_instr = 0; rs_busy = 0; cdb_valid = 0; cdb_tag = 0;
        a = 16'h0530; fifo.push_back(a);   // ADD r1,r2,r3
        a = 16'h5090; fifo.push_back(a);   // MUL r4,r1,r1
        a = 16'hC000; fifo.push_back(a);   // illegal opcode 110
        a = 16'h9109; fifo.push_back(a);   // LD r4,r2,#9
        q_full = 0; q_empty = 0;
        repeat (3) @(posedge CLK);
        #1 CLR = 0;

        n = 0;
        while (!issue_valid && n < 20) begin step(0, 0, 0); n++; end
        chk("first_latency", n, 4);
        repeat (30) step(0, 0, 0);

        repeat (1500) step(60, 40, 30);

        n = 0;
        while (!stall && n < 200) begin step(50, 100, 0); n++; end
        chk("stall_seen", int'(stall), 1);
        q_push = 0;
        #1 CLR = 1;
        #1;
        chk("async_clr_ctl", int'({q_pop, issue_valid, stall}), 0);
        chk("async_clr_rst", int'(rst_tags), 0);
        @(posedge CLK); #1 CLR = 0;

        repeat (1500) step(25, 30, 40);

        n = 0;
        while ((fifo.size() != 0 || expq.size() != 0) && n < 400) begin step(0, 0, 20); n++; end
        chk("drain", int'(fifo.size() + expq.size()), 0);
        repeat (5) step(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
